// File: rtl/caf_capture_pkg.sv
// Shared types and default sizing for the I/Q capture writer.
//   capture_state_t : writer FSM states
//   WDATA_W         : width of one {i,q} buffer word
package caf_capture_pkg;

  localparam int unsigned BUFFER_LENGTH  = 10;
  localparam int unsigned INDEX_BITS     = 4;
  localparam int unsigned I_BITS         = 12;
  localparam int unsigned Q_BITS         = 12;
  localparam int unsigned DECIM_BITS     = 8;
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned WDATA_W        = I_BITS + Q_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } capture_state_t;

endpackage

// File: rtl/capture_writer_if.sv
// Sample stream plus buffer write/response bus of the capture writer.
//   s_valid/s_i/s_q            : incoming I/Q sample stream
//   m_axi_waddr/wvalid/wdata   : buffer write port (writer drives)
//   s_axi_wready               : buffer can accept a write
//   s_axi_bvalid/bresp         : write response pulse and error flag
//   m_axi_bready               : writer accepts responses
// master = capture writer side, slave = source/buffer side.
interface capture_writer_if #(
  parameter int unsigned index_bits = caf_capture_pkg::INDEX_BITS,
  parameter int unsigned i_bits     = caf_capture_pkg::I_BITS,
  parameter int unsigned q_bits     = caf_capture_pkg::Q_BITS
);

  localparam int unsigned WD_W = i_bits + q_bits;

  logic                     s_valid;
  logic signed [i_bits-1:0] s_i;
  logic signed [q_bits-1:0] s_q;
  logic [index_bits-1:0]    m_axi_waddr;
  logic                     m_axi_wvalid;
  logic [WD_W-1:0]          m_axi_wdata;
  logic                     s_axi_wready;
  logic                     s_axi_bvalid;
  logic                     s_axi_bresp;
  logic                     m_axi_bready;

  modport master (
    input  s_valid, s_i, s_q, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    output m_axi_waddr, m_axi_wvalid, m_axi_wdata, m_axi_bready
  );

  modport slave (
    output s_valid, s_i, s_q, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    input  m_axi_waddr, m_axi_wvalid, m_axi_wdata, m_axi_bready
  );

endinterface

// File: rtl/capture_writer.sv
// Capture writer: once armed and triggered, writes buffer_length selected
// (decimated) I/Q samples to buffer addresses 0..buffer_length-1, then
// waits for all write responses (bounded by a timeout).
//   clk, rst        : clock, async active-high reset
//   arm, trigger    : start request / capture start qualifier
//   decim           : keep every (decim+1)th valid sample, latched on arm
//   bus (master)    : sample stream in, buffer write + response port
//   busy, done      : capture in progress / capture complete
//   overflow, error : sticky dropped-sample / bad-response-or-timeout flags
//   wr_count        : words written this capture
module capture_writer
  import caf_capture_pkg::*;
#(
  parameter int unsigned buffer_length  = BUFFER_LENGTH,
  parameter int unsigned index_bits     = INDEX_BITS,
  parameter int unsigned i_bits         = I_BITS,
  parameter int unsigned q_bits         = Q_BITS,
  parameter int unsigned decim_bits     = DECIM_BITS,
  parameter int unsigned timeout_cycles = TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [decim_bits-1:0] decim,
  capture_writer_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  error,
  output logic [index_bits:0]   wr_count
);

  localparam int unsigned CNT_W = index_bits + 1;
  localparam int unsigned TO_W  = $clog2(timeout_cycles + 1);
  localparam int unsigned WD_W  = i_bits + q_bits;

  capture_state_t        r_state;
  capture_state_t        w_state_nxt;

  logic [decim_bits-1:0] r_decim;
  logic [decim_bits-1:0] r_dec_cnt;
  logic [CNT_W-1:0]      r_wr_count;
  logic [CNT_W-1:0]      r_resp_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_wvalid;
  logic [index_bits-1:0] r_waddr;
  logic [WD_W-1:0]       r_wdata;
  logic                  r_bready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
  logic                  r_error;

  logic [CNT_W-1:0]      w_resp_nxt;
  logic                  w_resp_full;
  logic                  w_arm_ok;
  logic                  w_sampling;
  logic                  w_sel;
  logic                  w_issue;
  logic                  w_drop;
  logic                  w_last;
  logic                  w_timeout;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle strobes
  always_comb begin
    w_state_nxt = r_state;
    w_arm_ok    = 1'b0;
    w_sampling  = 1'b0;
    w_timeout   = 1'b0;
    // Counting the current response lets a same-cycle bvalid close the drain.
    w_resp_nxt  = r_resp_cnt + CNT_W'(bus.s_axi_bvalid);
    w_resp_full = (w_resp_nxt == CNT_W'(buffer_length));

    case (r_state)
      IDLE, DONE: begin
        if (arm) begin
          w_arm_ok    = 1'b1;
          w_state_nxt = ARMED;
        end
      end
      ARMED: begin
        // The trigger cycle's sample is the first sample of the capture.
        if (trigger) begin
          w_sampling  = 1'b1;
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: w_sampling = 1'b1;
      DRAIN: begin
        if (w_resp_full) begin
          w_state_nxt = DONE;
        end else if (r_to_cnt == TO_W'(timeout_cycles - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_sel   = w_sampling && bus.s_valid && (r_dec_cnt == '0);
    w_issue = w_sel && bus.s_axi_wready;
    w_drop  = w_sel && !bus.s_axi_wready;
    w_last  = w_issue && (r_wr_count == CNT_W'(buffer_length - 1));

    if (w_last) w_state_nxt = DRAIN;
  end

  // Counters, sticky flags and capture setup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_decim    <= '0;
      r_dec_cnt  <= '0;
      r_wr_count <= '0;
      r_resp_cnt <= '0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else if (w_arm_ok) begin
      r_decim    <= decim;
      r_dec_cnt  <= '0;
      r_wr_count <= '0;
      r_resp_cnt <= '0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_sampling && bus.s_valid)
        r_dec_cnt <= (r_dec_cnt == r_decim) ? '0 : r_dec_cnt + decim_bits'(1);
      if (w_issue)
        r_wr_count <= r_wr_count + CNT_W'(1);
      if (w_drop)
        r_overflow <= 1'b1;
      if (r_busy && bus.s_axi_bvalid) begin
        r_resp_cnt <= w_resp_nxt;
        if (bus.s_axi_bresp) r_error <= 1'b1;
      end
      if (w_timeout)
        r_error <= 1'b1;
    end
  end

  // Drain timeout counter, zero outside DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_to_cnt <= '0;
    else if (r_state == DRAIN) r_to_cnt <= r_to_cnt + TO_W'(1);
    else                      r_to_cnt <= '0;
  end

  // Registered write port and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wvalid <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_bready <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_wvalid <= w_issue;
      if (w_issue) begin
        r_waddr <= r_wr_count[index_bits-1:0];
        r_wdata <= {bus.s_i, bus.s_q};
      end
      r_bready <= (w_state_nxt != IDLE);
      r_busy   <= (w_state_nxt == ARMED) || (w_state_nxt == CAPTURE) ||
                  (w_state_nxt == DRAIN);
      r_done   <= (w_state_nxt == DONE);
    end
  end

  assign bus.m_axi_wvalid = r_wvalid;
  assign bus.m_axi_waddr  = r_waddr;
  assign bus.m_axi_wdata  = r_wdata;
  assign bus.m_axi_bready = r_bready;
  assign busy             = r_busy;
  assign done             = r_done;
  assign overflow         = r_overflow;
  assign error            = r_error;
  assign wr_count         = r_wr_count;

endmodule

// File: tb/tb_capture_writer.sv
// Directed bench for capture_writer: basic, decimated, backpressured,
// timeout, bad-response/ignored-arm and async-reset captures.
module tb_capture_writer;
  import caf_capture_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic       trigger;
  logic [7:0] decim;
  logic       busy;
  logic       done;
  logic       overflow;
  logic       error;
  logic [4:0] wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  capture_writer_if #(.index_bits(4), .i_bits(12), .q_bits(12)) bus ();

  capture_writer dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .trigger  (trigger),
    .decim    (decim),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .error    (error),
    .wr_count (wr_count)
  );

  // Write log and response model: each write gets a response one cycle later.
  int          n_wr         = 0;
  int          base         = 0;
  int          bad_idx      = 0;
  int          suppress_idx = 0;
  logic [3:0]  log_a [0:255];
  logic [23:0] log_d [0:255];

  always @(negedge clk) begin
    bus.s_axi_bvalid = 1'b0;
    bus.s_axi_bresp  = 1'b0;
    if (bus.m_axi_wvalid === 1'b1) begin
      log_a[n_wr % 256] = bus.m_axi_waddr;
      log_d[n_wr % 256] = bus.m_axi_wdata;
      n_wr++;
      if ((n_wr - base) != suppress_idx) begin
        bus.s_axi_bvalid = 1'b1;
        bus.s_axi_bresp  = ((n_wr - base) == bad_idx);
      end
    end
  end

  logic [23:0] exp_d [0:15];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] iq(input int i, input int q);
    logic [11:0] a;
    logic [11:0] b;
    a = 12'(i);
    b = 12'(q);
    return {a, b};
  endfunction

  task automatic do_arm(input logic [7:0] d);
    decim = d;
    arm   = 1'b1;
    tick();
    arm   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 100 && done !== 1'b1; c++) tick();
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Ten writes since base, at addresses 0..9 with data exp_d[]
  task automatic verify_writes(input string tag);
    check({tag, "_nwrites"}, 32'(n_wr - base), 32'd10);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("%s_addr%0d", tag, j), 32'(log_a[(base + j) % 256]), 32'(j));
      check($sformatf("%s_data%0d", tag, j), 32'(log_d[(base + j) % 256]), 32'(exp_d[j]));
    end
    check({tag, "_wr_count"}, 32'(wr_count), 32'd10);
  endtask

  task automatic sample(input int i, input int q);
    bus.s_valid = 1'b1;
    bus.s_i     = 12'(i);
    bus.s_q     = 12'(q);
    tick();
    trigger     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trigger = 1'b0; decim = '0;
    bus.s_valid = 1'b0; bus.s_i = '0; bus.s_q = '0; bus.s_axi_wready = 1'b1;
    repeat (3) tick();
    check("rst_busy",   32'(busy),             32'd0);
    check("rst_done",   32'(done),             32'd0);
    check("rst_wvalid", 32'(bus.m_axi_wvalid), 32'd0);
    check("rst_bready", 32'(bus.m_axi_bready), 32'd0);
    check("rst_wrcnt",  32'(wr_count),         32'd0);
    rst = 1'b0;
    tick();

    // 1: basic capture, trigger together with the first sample
    base = n_wr; bad_idx = 0; suppress_idx = 0;
    do_arm(8'd0);
    check("t1_busy_armed", 32'(busy),             32'd1);
    check("t1_bready",     32'(bus.m_axi_bready), 32'd1);
    trigger = 1'b1;
    for (int k = 1; k <= 10; k++) sample(k, -k);
    bus.s_valid = 1'b0;
    check("t1_done_early", 32'(done), 32'd0);
    check("t1_busy_drain", 32'(busy), 32'd1);
    tick();
    check("t1_done_time", 32'(done),     32'd1);
    check("t1_busy_off",  32'(busy),     32'd0);
    check("t1_overflow",  32'(overflow), 32'd0);
    check("t1_error",     32'(error),    32'd0);
    for (int j = 0; j < 10; j++) exp_d[j] = iq(j + 1, -(j + 1));
    verify_writes("t1");

    // 2: decim=2 keeps samples 0,3,...,27
    base = n_wr;
    do_arm(8'd2);
    check("t2_done_clr", 32'(done), 32'd0);
    trigger = 1'b1;
    for (int n = 0; n < 30; n++) sample(n, n + 100);
    bus.s_valid = 1'b0;
    wait_done("t2");
    for (int j = 0; j < 10; j++) exp_d[j] = iq(3 * j, 3 * j + 100);
    verify_writes("t2");
    check("t2_error", 32'(error), 32'd0);

    // 3: wready low for sample 4 drops it
    base = n_wr;
    do_arm(8'd0);
    trigger = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      bus.s_axi_wready = (n != 4);
      sample(n + 7, n);
    end
    bus.s_valid = 1'b0; bus.s_axi_wready = 1'b1;
    wait_done("t3");
    for (int j = 0; j < 10; j++) exp_d[j] = (j < 4) ? iq(j + 7, j) : iq(j + 8, j + 1);
    verify_writes("t3");
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_error",    32'(error),    32'd0);

    // 4: tenth response never arrives -> DONE after 64 DRAIN cycles
    base = n_wr; suppress_idx = 10;
    do_arm(8'd0);
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    trigger = 1'b1;
    for (int k = 1; k <= 10; k++) sample(k, k);
    bus.s_valid = 1'b0;
    repeat (63) tick();
    check("t4_done_63", 32'(done),  32'd0);
    check("t4_busy_63", 32'(busy),  32'd1);
    check("t4_err_63",  32'(error), 32'd0);
    tick();
    check("t4_done_64", 32'(done),     32'd1);
    check("t4_error",   32'(error),    32'd1);
    check("t4_wrcnt",   32'(wr_count), 32'd10);
    suppress_idx = 0;

    // 5: bresp=1 on third response, arm pulsed mid-capture
    base = n_wr; bad_idx = 3;
    do_arm(8'd0);
    check("t5_err_clr", 32'(error), 32'd0);
    trigger = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      arm = (k == 6);
      sample(k + 20, k);
    end
    arm = 1'b0; bus.s_valid = 1'b0;
    wait_done("t5");
    check("t5_error", 32'(error), 32'd1);
    for (int j = 0; j < 10; j++) exp_d[j] = iq(j + 21, j + 1);
    verify_writes("t5");
    bad_idx = 0;

    // 6: async reset after five writes, then a fresh capture from addr 0
    base = n_wr;
    do_arm(8'd0);
    trigger = 1'b1;
    for (int k = 1; k <= 5; k++) sample(k, k);
    bus.s_valid = 1'b0;
    check("t6_pre_wrcnt", 32'(wr_count), 32'd5);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_busy",   32'(busy),             32'd0);
    check("t6_rst_done",   32'(done),             32'd0);
    check("t6_rst_ovf",    32'(overflow),         32'd0);
    check("t6_rst_err",    32'(error),            32'd0);
    check("t6_rst_wrcnt",  32'(wr_count),         32'd0);
    check("t6_rst_wvalid", 32'(bus.m_axi_wvalid), 32'd0);
    check("t6_rst_waddr",  32'(bus.m_axi_waddr),  32'd0);
    check("t6_rst_wdata",  32'(bus.m_axi_wdata),  32'd0);
    check("t6_rst_bready", 32'(bus.m_axi_bready), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_idle_busy", 32'(busy), 32'd0);
    base = n_wr;
    do_arm(8'd0);
    trigger = 1'b1;
    for (int k = 1; k <= 10; k++) sample(k + 40, -k);
    bus.s_valid = 1'b0;
    wait_done("t6");
    for (int j = 0; j < 10; j++) exp_d[j] = iq(j + 41, -(j + 1));
    verify_writes("t6");
    check("t6_error", 32'(error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_writer.md
Name: capture_writer

Overview:
Upstream feeder for the I/Q capture buffer. It takes a streaming I/Q sample source and, once armed and triggered, writes `buffer_length` consecutive (optionally decimated) samples into the buffer's write port as `{i,q}` words at addresses 0..buffer_length-1. It counts write responses to confirm completion and reports done, overflow and timeout status to the controlling logic.

Parameters:
- buffer_length, 10, number of samples per capture; must be ≤ 2**index_bits
- index_bits, 4, address width of the buffer write port
- i_bits, 12, signed I sample width
- q_bits, 12, signed Q sample width
- decim_bits, 8, width of runtime decimation control
- timeout_cycles, 64, max cycles in DRAIN waiting for outstanding responses

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle request to start a capture
- trigger  in  1  capture start qualifier, sampled while ARMED
- decim  in  decim_bits  write every (decim+1)th valid sample; latched on arm
- s_valid  in  1  input sample valid
- s_i  in  i_bits  input I sample (signed)
- s_q  in  q_bits  input Q sample (signed)
- m_axi_waddr  out  index_bits  buffer write address
- m_axi_wvalid  out  1  write strobe, one cycle per word
- m_axi_wdata  out  i_bits+q_bits  {s_i, s_q}, I in the MSBs
- s_axi_wready  in  1  buffer ready to accept a write
- s_axi_bvalid  in  1  write response pulse
- s_axi_bresp  in  1  write response code, 1 = error
- m_axi_bready  out  1  response accept
- busy  out  1  high in ARMED, CAPTURE and DRAIN
- done  out  1  capture complete; level until next accepted arm
- overflow  out  1  sticky: a selected sample was dropped because wready was low
- error  out  1  sticky: bresp=1 seen or DRAIN timeout
- wr_count  out  index_bits+1  words written this capture

Behaviour:
- **Reset values.** All outputs are 0; state = IDLE. Reset mid-capture abandons the capture; the buffer contents are left undefined.
- **States.** IDLE, ARMED, CAPTURE, DRAIN, DONE.
- **IDLE/DONE → ARMED** on `arm`:
  - latch `decim`;
  - clear done, overflow, error, wr_count, the response count and the decimation counter.
  - `arm` in ARMED, CAPTURE or DRAIN is ignored.
- **ARMED → CAPTURE** when `trigger`=1. A sample with `s_valid` in the same cycle as the trigger counts as the first sample and is written.
- **Sample selection in CAPTURE:**
  - On each `s_valid`, the decimation counter increments; a sample is selected when the counter is 0, and the counter wraps at the latched `decim`.
  - With decim=0, every valid sample is selected.
- **Write issue:**
  - A selected sample with `s_axi_wready`=1 drives `m_axi_wvalid`=1, `m_axi_waddr`=wr_count and `m_axi_wdata`={s_i,s_q}. All three are registered, so they appear one cycle after the sample.
  - wr_count increments on each issued write.
  - A selected sample with `s_axi_wready`=0 is dropped: overflow←1, the address does not advance, and the capture continues.
  - `m_axi_wvalid` is a single-cycle pulse per write, never held.
- **CAPTURE → DRAIN** in the cycle the write for address buffer_length-1 issues. No further writes are issued.
- **Responses:**
  - `m_axi_bready` = 1 whenever state ≠ IDLE.
  - Each `s_axi_bvalid` increments the response count.
  - `s_axi_bresp`=1 together with bvalid sets error.
  - Responses arriving in CAPTURE are also counted.
- **DRAIN → DONE** when the response count = buffer_length. A response arriving in the same cycle as the last write issue is counted.
- **DRAIN timeout.** A counter runs in DRAIN. On reaching timeout_cycles: error←1 and go to DONE.
- **DONE:** done=1, busy=0. Stays in DONE until the next `arm`.
- **Width rules.** wr_count and the response count are index_bits+1 wide, so buffer_length = 2**index_bits counts without wrap. Addresses never exceed buffer_length-1.

Decomposition:
- Shared package `caf_capture_pkg`:
  - state enum `capture_state_t` (IDLE, ARMED, CAPTURE, DRAIN, DONE);
  - localparam `WDATA_W` = i_bits+q_bits.
- Single flat module; no sub-module required.

Test Plan:
1. **Basic capture.** buffer_length=10, decim=0, arm, then trigger, then 10 consecutive valid samples I=k, Q=-k → writes to addr 0..9 with wdata {k,-k}; done=1 one cycle after the 10th bvalid; wr_count=10; overflow=0, error=0.
2. **Decimation.** decim=2, 30 valid samples numbered 0..29 → samples 0,3,6,…,27 written to addr 0..9; no write for any other sample.
3. **Backpressure.** wready low for sample 4 → sample 4 dropped, sample 5 written at addr 4, overflow=1; capture still completes with 10 writes.
4. **Timeout.** Responder suppresses the final bvalid → DONE after exactly 64 DRAIN cycles with error=1, done=1.
5. **Bad response and ignored arm.** bresp=1 on the 3rd response → error=1 at completion. `arm` pulsed mid-CAPTURE → ignored, addresses continue.
6. **Async reset.** rst asserted mid-CAPTURE (after 5 writes) → all outputs 0 immediately, state IDLE. A new arm/trigger restarts writing at addr 0.
